// File: rtl/dlmiles_loopback_skew.sv
// Loopback tile: routes ui_in to uo_out through a mode-selected transform
// (combinational, registered, delay line, per-bit skew, invert, reverse, counter, edge detect).
module dlmiles_loopback_skew #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    M_COMB  = 3'd0,
    M_REG   = 3'd1,
    M_DELAY = 3'd2,
    M_SKEW  = 3'd3,
    M_INV   = 3'd4,
    M_REV   = 3'd5,
    M_CNT   = 3'd6,
    M_EDGE  = 3'd7
  } mode_e;

  mode_e      mode;
  logic [2:0] dsel;
  logic [7:0] h [DEPTH];
  logic [7:0] cnt;
  logic [7:0] skew;
  logic [7:0] rev;
  logic       unused_cfg;

  assign mode       = mode_e'(uio_in[2:0]);
  assign dsel       = uio_in[5:3];
  assign unused_cfg = &{1'b0, uio_in[7:6]};

  assign uio_out = '0;
  assign uio_oe  = '0;

  // History runs regardless of mode so a newly selected delay shows real past data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) h[k] <= '0;
      cnt <= '0;
    end else if (ena) begin
      h[0] <= ui_in;
      for (int unsigned k = 1; k < DEPTH; k++) h[k] <= h[k-1];
      cnt <= cnt + 8'd1;
    end
  end

  // Bit i is taken from stage i-1, giving i cycles of latency on bit i.
  always_comb begin
    skew    = '0;
    skew[0] = ui_in[0];
    for (int unsigned i = 1; i < 8; i++) skew[i] = h[i-1][i];
  end

  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < 8; i++) rev[i] = ui_in[7-i];
  end

  always_comb begin
    uo_out = '0;
    case (mode)
      M_COMB:  uo_out = ui_in;
      M_REG:   uo_out = h[0];
      M_DELAY: uo_out = h[dsel];
      M_SKEW:  uo_out = skew;
      M_INV:   uo_out = ~ui_in;
      M_REV:   uo_out = rev;
      M_CNT:   uo_out = cnt;
      M_EDGE:  uo_out = h[0] ^ ui_in;
      default: uo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_dlmiles_loopback_skew.sv
// Scoreboard bench: stimulus queues expected uo_out values, a negedge monitor pops and checks them.
module tb_dlmiles_loopback_skew;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  dlmiles_loopback_skew #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares at the falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    total++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      bad++;
      $display("FAIL uio_tie: uio_oe=%h uio_out=%h required 00/00", uio_oe, uio_out);
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (uo_out !== e.exp) begin
        bad++;
        $display("FAIL %s: uo_out=%h required %h", e.name, uo_out, e.exp);
      end
    end
  end

  // Drive inputs just after a rising edge; the expectation is checked at the following falling edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] cfg,
                       input logic [7:0] exp, input bit chk, input string nm);
    @(posedge clk);
    #1;
    rst    = r;
    ena    = e;
    ui_in  = ui;
    uio_in = cfg;
    if (chk) q.push_back('{name: nm, exp: exp});
  endtask

  task automatic flush();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, "flush");
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Combinational modes follow ui_in during reset; registered ones read 0.
    drive(1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5, 1'b1, "m0_in_reset");
    drive(1'b1, 1'b1, 8'hA5, 8'h04, 8'h5A, 1'b1, "m4_in_reset");
    drive(1'b1, 1'b1, 8'hA5, 8'h01, 8'h00, 1'b1, "m1_in_reset");
    drive(1'b1, 1'b1, 8'hA5, 8'h06, 8'h00, 1'b1, "m6_in_reset");

    // Mode 1 sequence after reset release.
    drive(1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1, "m1_first");
    drive(1'b0, 1'b1, 8'h02, 8'h01, 8'h01, 1'b1, "m1_lag1");
    drive(1'b0, 1'b1, 8'h03, 8'h01, 8'h02, 1'b1, "m1_lag2");
    drive(1'b0, 1'b1, 8'h00, 8'h01, 8'h03, 1'b1, "m1_lag3");
    flush();

    // Mode 2, D=7 with unused bits set: pulse appears on the 8th check after driving.
    drive(1'b0, 1'b1, 8'hFF, 8'hFA, 8'h00, 1'b1, "m2_d7_pulse");
    for (int k = 1; k <= 9; k++)
      drive(1'b0, 1'b1, 8'h00, 8'hFA, (k == 8) ? 8'hFF : 8'h00, 1'b1, "m2_d7_delay");
    drive(1'b0, 1'b1, 8'hFF, 8'hC2, 8'h00, 1'b1, "m2_d0_pulse");
    drive(1'b0, 1'b1, 8'h00, 8'hC2, 8'hFF, 1'b1, "m2_d0_lag1");
    drive(1'b0, 1'b1, 8'h00, 8'hC2, 8'h00, 1'b1, "m2_d0_after");
    flush();

    // Mode 3 staircase.
    drive(1'b0, 1'b1, 8'hFF, 8'h03, 8'h01, 1'b1, "m3_step0");
    for (int k = 1; k <= 7; k++) begin
      logic [8:0] m;
      m = (9'd1 << (k + 1)) - 9'd1;
      drive(1'b0, 1'b1, 8'hFF, 8'h03, m[7:0], 1'b1, "m3_step");
    end

    // Mode 7 edge detect, then mode 5 reversal.
    drive(1'b0, 1'b1, 8'h0F, 8'h07, 8'hF0, 1'b1, "m7_from_ff");
    drive(1'b0, 1'b1, 8'h3C, 8'h07, 8'h33, 1'b1, "m7_0f_3c");
    drive(1'b0, 1'b1, 8'h01, 8'h05, 8'h80, 1'b1, "m5_01");
    drive(1'b0, 1'b1, 8'hB4, 8'h05, 8'h2D, 1'b1, "m5_b4");

    // History freezes while ena is low.
    drive(1'b1, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1, "m1_reset_mid");
    drive(1'b0, 1'b1, 8'h5C, 8'h01, 8'h00, 1'b1, "ena_pre");
    drive(1'b0, 1'b0, 8'h77, 8'h01, 8'h5C, 1'b1, "ena_hold_a");
    drive(1'b0, 1'b0, 8'h99, 8'h01, 8'h5C, 1'b1, "ena_hold_b");
    drive(1'b0, 1'b1, 8'h00, 8'h01, 8'h5C, 1'b1, "ena_hold_c");
    drive(1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b1, "ena_resume");

    // Mode 6 counter: reset mid-cycle, count 300 clocks, hold, then async reset.
    drive(1'b1, 1'b1, 8'h00, 8'h06, 8'h00, 1'b1, "m6_async_clr");
    for (int n = 1; n <= 300; n++)
      drive(1'b0, 1'b1, 8'h00, 8'h06, 8'((n - 1) % 256),
            (n == 1) || (n == 2) || (n == 256) || (n == 257), "m6_count");
    drive(1'b0, 1'b0, 8'h00, 8'h06, 8'h2C, 1'b1, "m6_300");
    for (int n = 0; n < 5; n++)
      drive(1'b0, 1'b0, 8'h00, 8'h06, 8'h2C, 1'b1, "m6_ena_hold");
    drive(1'b1, 1'b0, 8'h00, 8'h06, 8'h00, 1'b1, "m6_async_rst");
    drive(1'b1, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b1, "m0_rst_end");

    begin
      int waited;
      waited = 0;
      while (q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (q.size() > 0) begin
        bad++;
        total++;
        $display("FAIL drain: pending=%0d required 0", q.size());
      end
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlmiles_loopback_skew.md
Name: dlmiles_loopback_skew

Overview:
- Tiny-tapeout style user tile that loops the 8-bit dedicated input bus `ui_in` back to the dedicated output bus `uo_out`.
- A mode field on the bidirectional pins selects one of several transforms: pure combinational, registered, programmable delay, per-bit skew, inverted, bit-reversed, or a counter.
- Used for pad and board loopback characterisation and for measuring clock-to-output skew on silicon.

Parameters:
- DEPTH, 8, number of history stages in the delay line. Must be ≥ 8 so that mode 3 has enough stages. Only 8 needs to be supported.

Ports:
- clk      input   1  system clock, rising-edge
- rst      input   1  asynchronous, active-high reset
- ena      input   1  tile enable; when low, all registers hold their value
- ui_in    input   8  loopback data input
- uo_out   output  8  loopback data output
- uio_in   input   8  config: [2:0] mode, [5:3] delay select D, [7:6] unused
- uio_out  output  8  tied to 0
- uio_oe   output  8  tied to 0 (all uio pins are inputs)

Behaviour:
- Reset:
  - While `rst` is high, all history stages h[0..7] and counter `cnt` are cleared to 0 immediately, without waiting for a clock edge.
  - Registered modes therefore output 0 during reset.
  - Combinational modes (0, 4, 5) keep following `ui_in` during reset.
- History shift register (always runs, independent of mode):
  - On each rising `clk` edge with `ena`=1: h[0] <= ui_in, and h[k] <= h[k-1] for k = 1..7.
  - With `ena`=0, all h stages hold.
- Counter: on each rising `clk` edge with `ena`=1, `cnt` <= `cnt`+1, modulo 256 (255 wraps to 0). Holds when `ena`=0.
- Mode decode (mode = `uio_in[2:0]`, read combinationally, no mode register):
  - 0: uo_out = ui_in (zero latency, combinational).
  - 1: uo_out = h[0] (1-cycle latency).
  - 2: uo_out = h[D], where D = `uio_in[5:3]`. Latency is D+1 cycles, range 1..8.
  - 3: per-bit skew. uo_out[0] = ui_in[0] (0 cycles); for i = 1..7, uo_out[i] = h[i-1][i] (i cycles latency).
  - 4: uo_out = ~ui_in (combinational).
  - 5: uo_out[i] = ui_in[7-i] (combinational bit reversal).
  - 6: uo_out = cnt.
  - 7: uo_out = h[0] XOR ui_in. This is an edge detector: a bit is 1 when that input bit changed since the last clock.
- Mode or D changes take effect combinationally in the same cycle. History is continuous, so switching into a delay mode shows the true past input immediately, with no refill period.
- Reset asserted mid-operation: history and counter clear immediately. After release, delay modes output 0 until real data propagates through; the counter restarts at 0.
- `ena` low: registered outputs freeze at their last value; combinational modes still track `ui_in`.
- `uio_in[7:6]` are ignored.
- No X propagation from unused pins.

Test Plan:
- Mode 0 and mode 4, `ui_in`=0xA5: `uo_out`=0xA5 in mode 0 and 0x5A in mode 4, with no clock edge needed; same result with `rst`=1.
- Mode 1: apply the sequence 0x01, 0x02, 0x03 on successive clocks after reset. `uo_out` is 0x00 on the first cycle after reset release, then lags by one cycle (0x01, 0x02, 0x03).
- Mode 2, D=7: pulse `ui_in`=0xFF for one cycle, otherwise 0x00. `uo_out` is 0xFF exactly 8 cycles after the pulse is sampled, for one cycle. Repeat with D=0 to confirm a 1-cycle latency.
- Mode 3: step `ui_in` from 0x00 to 0xFF. `uo_out` goes 0x01 immediately, then 0x03, 0x07, …, reaching 0xFF after 7 clocks.
- Mode 6: count 300 clocks from reset with `ena`=1. `uo_out`=300 mod 256 = 44 (0x2C). Then hold `ena` low for 5 clocks: the value stays 0x2C. Assert `rst` asynchronously between edges: `uo_out`=0x00 immediately.
- Mode 5 and mode 7: in mode 5, `ui_in`=0x01 gives `uo_out`=0x80. In mode 7, with h[0]=0x0F and `ui_in`=0x3C, `uo_out`=0x33. Check `uio_oe` and `uio_out` are 0x00 throughout all scenarios.
